// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, OP encodings and FSM state type for the ALU share controller
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 7;

    localparam logic [OP_W-1:0] OP_ADD = 7'b000_0001;
    localparam logic [OP_W-1:0] OP_INC = 7'b000_0100;
    localparam logic [OP_W-1:0] OP_DEC = 7'b001_0000;

    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - 2-way round-robin grant; ALU_SHARE_FIXED_PRIO_EN selects strict port-0 priority
module alu_share_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

`ifdef ALU_SHARE_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = clk ^ rst_n ^ upd;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] && !req[0];
    end
`else
    // rr_last resets to 1 so port 0 wins the first contested cycle
    logic rr_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (upd) begin
            rr_last <= gnt[1];
        end
    end

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] && (!req[1] || rr_last);
        gnt[1] = req[1] && (!req[0] || !rr_last);
    end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one ALU between execute (port 0) and stack/irq (port 1); see ALU_SHARE_FIXED_PRIO_EN in alu_share_arb
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [OP_W-1:0]   r0_op,
    input  logic              r0_setf,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [OP_W-1:0]   r1_op,
    input  logic              r1_setf,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_cf,
    output logic              rsp_nf,
    output logic              rsp_zf,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_en,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cf,
    input  logic              alu_nf,
    input  logic              alu_zf,
    output logic [2:0]        ccr
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]     op_q;
    logic                setf_q, owner_q;
    logic [1:0]          gnt;
    logic                arb_en, accept, op_ok, err;

    // One-hot test: nonzero and clearing the lowest set bit leaves nothing
    assign op_ok = (op_q != '0) && ((op_q & (op_q - OP_W'(1))) == '0);

    assign arb_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready[owner_q]);

    alu_share_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({r1_valid, r0_valid}),
        .upd   (accept),
        .gnt   (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? EXEC : IDLE;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready[owner_q]) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r0_ready  = arb_en && gnt[0];
        r1_ready  = arb_en && gnt[1];
        accept    = r0_ready || r1_ready;
        rsp_valid = (state_q == RESP) ? {owner_q, !owner_q} : 2'b00;
        alu_en    = (state_q == EXEC) && op_ok;
        err       = (state_q == EXEC) && !op_ok;
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            setf_q   <= 1'b0;
            owner_q  <= 1'b0;
            rsp_data <= '0;
            rsp_cf   <= 1'b0;
            rsp_nf   <= 1'b0;
            rsp_zf   <= 1'b0;
            rsp_err  <= 1'b0;
            ccr      <= 3'b000;
        end else begin
            if (accept) begin
                a_q     <= r1_ready ? r1_a    : r0_a;
                b_q     <= r1_ready ? r1_b    : r0_b;
                op_q    <= r1_ready ? r1_op   : r0_op;
                setf_q  <= r1_ready ? r1_setf : r0_setf;
                owner_q <= r1_ready;
            end
            if (state_q == EXEC) begin
                rsp_data <= err ? '0 : alu_result;
                rsp_cf   <= alu_cf && !err;
                rsp_nf   <= alu_nf && !err;
                rsp_zf   <= alu_zf && !err;
                rsp_err  <= err;
                if (setf_q && !err) begin
                    ccr[CCR_C] <= alu_cf;
                    ccr[CCR_N] <= alu_nf;
                    ccr[CCR_Z] <= alu_zf;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed vector bench for alu_share_ctrl with a behavioural ALU
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic [6:0]  r0_op, r1_op;
    logic        r0_setf, r1_setf;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_cf, rsp_nf, rsp_zf, rsp_err;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [6:0]  alu_op;
    logic        alu_en, alu_cf, alu_nf, alu_zf;
    logic [2:0]  ccr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_setf(r0_setf),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_setf(r1_setf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cf(rsp_cf), .rsp_nf(rsp_nf), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
        .alu_result(alu_result), .alu_cf(alu_cf), .alu_nf(alu_nf), .alu_zf(alu_zf),
        .ccr(ccr)
    );

    // Behavioural ALU; non-one-hot OPs return nonzero garbage so forced zeroing is observable
    always_comb begin
        logic [16:0] s;
        s = {1'b0, alu_a | alu_b} | 17'h10000;
        case (alu_op)
            7'b000_0001: s = {1'b0, alu_a} + {1'b0, alu_b};
            7'b000_0100: s = {1'b0, alu_a} + 17'd1;
            7'b001_0000: s = {1'b0, alu_a - 16'd1};
            default:     s = {1'b1, alu_a | alu_b};
        endcase
        alu_result = s[15:0];
        alu_cf     = s[16];
        alu_nf     = s[15];
        alu_zf     = (s[15:0] == 16'h0000);
    end

    typedef struct {
        logic        port;
        logic [15:0] a;
        logic [15:0] b;
        logic [6:0]  op;
        logic        setf;
        logic [15:0] exp_data;
        logic [2:0]  exp_cnz;
        logic        exp_err;
        logic [2:0]  exp_ccr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [6:0] op, input logic setf);
        if (port) begin
            r1_valid = v; r1_a = a; r1_b = b; r1_op = op; r1_setf = setf;
        end else begin
            r0_valid = v; r0_a = a; r0_b = b; r0_op = op; r0_setf = setf;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] onehot_port;
        onehot_port = v.port ? 2'b10 : 2'b01;
        drive(v.port, 1'b1, v.a, v.b, v.op, v.setf);
        #1;
        chk("vec_ready", {r1_ready, r0_ready}, onehot_port);
        tick();
        drive(v.port, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        #1;
        chk("vec_alu_en", alu_en, !v.exp_err);
        chk("vec_alu_op", alu_op, v.op);
        tick();
        chk("vec_rsp_valid", rsp_valid, onehot_port);
        chk("vec_rsp_data", rsp_data, v.exp_data);
        chk("vec_rsp_cnz", {rsp_cf, rsp_nf, rsp_zf}, v.exp_cnz);
        chk("vec_rsp_err", rsp_err, v.exp_err);
        chk("vec_ccr", ccr, v.exp_ccr);
        rsp_ready = onehot_port;
        tick();
        rsp_ready = 2'b00;
        #1;
        chk("vec_retired", rsp_valid, 2'b00);
    endtask

    initial begin
        logic [1:0] exp_g[4];

        //            port a        b        op           setf data     cnz     err   ccr
        vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 7'b000_0001, 1'b1, 16'h0000, 3'b101, 1'b0, 3'b101};
        vecs[1] = '{1'b1, 16'h0000, 16'h0001, 7'b001_0000, 1'b0, 16'hFFFF, 3'b010, 1'b0, 3'b101};
        vecs[2] = '{1'b0, 16'h1234, 16'h0001, 7'b000_0011, 1'b1, 16'h0000, 3'b000, 1'b1, 3'b101};
        vecs[3] = '{1'b1, 16'h7FFF, 16'h0000, 7'b000_0100, 1'b1, 16'h8000, 3'b010, 1'b0, 3'b010};
        vecs[4] = '{1'b0, 16'h0001, 16'h0002, 7'b000_0001, 1'b1, 16'h0003, 3'b000, 1'b0, 3'b000};
        vecs[5] = '{1'b1, 16'h00F0, 16'h000F, 7'b000_0000, 1'b1, 16'h0000, 3'b000, 1'b1, 3'b000};

`ifdef ALU_SHARE_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        rst_n = 1'b0;
        rsp_ready = 2'b00;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ccr", ccr, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_ready", {r1_ready, r0_ready}, 2'b00);
        chk("rst_rsp_data", rsp_data, 16'h0000);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Contention: last accept was port 1, so port 0 leads the alternation
        rsp_ready = 2'b11;
        drive(1'b0, 1'b1, 16'h0001, 16'h0000, 7'b000_0100, 1'b0);
        drive(1'b1, 1'b1, 16'h0001, 16'h0000, 7'b000_0100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", {r1_ready, r0_ready}, exp_g[k]);
            tick();
            chk("rr_exec_en", alu_en, 1'b1);
            tick();
            chk("rr_rsp_valid", rsp_valid, exp_g[k]);
            chk("rr_rsp_data", rsp_data, 16'h0002);
            if (k == 3) begin
                drive(1'b0, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
                drive(1'b1, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
            end
        end
        tick();
        rsp_ready = 2'b00;
        #1;
        chk("rr_idle", rsp_valid, 2'b00);
        chk("rr_ccr_held", ccr, 3'b000);

        // Backpressure on port 0 response while port 1 waits
        drive(1'b0, 1'b1, 16'h0005, 16'h0006, 7'b000_0001, 1'b0);
        #1;
        chk("bp_r0_ready", r0_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        drive(1'b1, 1'b1, 16'h0009, 16'h0000, 7'b000_0100, 1'b0);
        #1;
        chk("bp_exec_r1_ready", r1_ready, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", rsp_valid, 2'b01);
            chk("bp_hold_data", rsp_data, 16'h000B);
            chk("bp_hold_r1_ready", r1_ready, 1'b0);
            tick();
        end
        rsp_ready = 2'b01;
        #1;
        chk("bp_r1_accept", r1_ready, 1'b1);
        tick();
        rsp_ready = 2'b00;
        drive(1'b1, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        #1;
        chk("bp_r1_exec_en", alu_en, 1'b1);
        chk("bp_r1_exec_a", alu_a, 16'h0009);
        tick();
        chk("bp_r1_rsp_valid", rsp_valid, 2'b10);
        chk("bp_r1_rsp_data", rsp_data, 16'h000A);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // Reset during EXEC of a flag-setting op
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 7'b000_0001, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        #1;
        chk("mid_rst_exec_en", alu_en, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 2'b00);
        chk("mid_rst_ccr", ccr, 3'b000);
        chk("mid_rst_alu_en", alu_en, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_rst_no_rsp", rsp_valid, 2'b00);
            chk("mid_rst_ccr_hold", ccr, 3'b000);
        end

        // After reset both valid: port 0 must win
        drive(1'b0, 1'b1, 16'h0001, 16'h0000, 7'b000_0100, 1'b0);
        drive(1'b1, 1'b1, 16'h0001, 16'h0000, 7'b000_0100, 1'b0);
        #1;
        chk("post_rst_grant", {r1_ready, r0_ready}, 2'b01);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 7'h0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares the single 16-bit ALU (alu_16bit) between two requesters: port 0 is the execute stage and port 1 is the stack/interrupt unit.
- Accepts one operation at a time via valid/ready and drives the ALU operand, OP and En inputs from registered values.
- Captures Result and the C/N/Z flags, and returns them to the owning requester.
- Maintains the architectural flag register (CCR) that the branch unit reads.

Parameters:
- DATA_W, 16, operand/result width
- OP_W, 7, ALU OP field width; one-hot encoded (000_0001 ADD, 000_0100 INC, 001_0000 DEC, ...)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- r0_valid / r1_valid  in  1  request valid
- r0_ready / r1_ready  out  1  request accepted this cycle when valid&&ready
- r0_a, r0_b / r1_a, r1_b  in  DATA_W  operands
- r0_op / r1_op  in  OP_W  ALU OP
- r0_setf / r1_setf  in  1  commit flags to CCR
- rsp_valid  out  2  one-hot, indicates the owner of the pending response
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  DATA_W  captured result
- rsp_cf, rsp_nf, rsp_zf  out  1  captured flags
- rsp_err  out  1  illegal OP
- alu_a, alu_b  out  DATA_W  to FirstOperand/SeconedOperand
- alu_op  out  OP_W  to OP
- alu_en  out  1  to En
- alu_result  in  DATA_W  from Result
- alu_cf, alu_nf, alu_zf  in  1  from CarryFlag/NegativeFlag/ZeroFlag
- ccr  out  3  {C,N,Z} architectural flags

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0 (ready, rsp_valid, rsp_*, alu_*, ccr=3'b000); rr_last=1, so port 0 wins first. Reset mid-operation discards the in-flight op; no response is produced and CCR is not written.
- FSM states: IDLE, EXEC, RESP.
- IDLE: ready is asserted combinationally only to the arbitration winner among valid ports (never both). On accept, latch a/b/op/setf and owner, then go to EXEC.
- Arbitration: if both ports are valid, grant the port != rr_last; update rr_last=owner on accept. A single valid port always wins.
- EXEC (exactly 1 cycle):
  - alu_a/b/op are driven from the latch registers.
  - alu_en=1 only if op is one-hot (exactly one bit set); otherwise alu_en=0 and err=1.
  - At the end of the cycle, capture alu_result/flags into the rsp registers (forced to 0 when err). Go to RESP.
  - Outside EXEC, alu_en=0 and alu_a/b/op hold their last values.
- CCR update: on the EXEC->RESP edge, if setf && !err, ccr <= {alu_cf, alu_nf, alu_zf}; otherwise ccr holds. The new value is visible in the cycle RESP is entered.
- RESP: rsp_valid[owner]=1; data/flags/err are stable until handshake. When rsp_ready[owner] is high the op retires.
  - In the same cycle, arbitration runs as in IDLE. On an accept, go directly to EXEC; otherwise go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency: accept at cycle N gives rsp_valid at N+2. Peak throughput is 1 op / 2 cycles.
- Requester rules:
  - A valid request must hold its payload stable until ready.
  - ready is never asserted to a port while a response to that port is pending and unacknowledged, except in the same cycle that response is accepted.
- Widths: no arithmetic is performed in the block; all values pass unmodified.

Optional Feature:
- Macro ALU_SHARE_FIXED_PRIO_EN.
- Defined: port 0 has strict priority, and rr_last is not instantiated. Port 1 wins only when r0_valid=0.
- Undefined: round-robin as above.

Decomposition:
- A shared package alu_pkg holds:
  - OP_W and DATA_W constants
  - one-hot OP localparams (OP_ADD, OP_INC, OP_DEC, ...)
  - state encoding (IDLE/EXEC/RESP)
  - the CCR bit index constants (CCR_C=2, CCR_N=1, CCR_Z=0)
- One sub-module, alu_share_arb: a 2-way round-robin/fixed-priority grant with an update strobe. The macro lives only there.

Test Plan:
- After rst_n low for 2 cycles then high: ccr=000, rsp_valid=00, alu_en=0. r0 request ADD a=FFFF b=0001 setf=1: r0_ready same cycle; at +2 rsp_valid=01, rsp_data=0000, CF=1, ZF=1, NF=0; ccr=3'b101.
- r1 request DEC a=0000 b=0001 setf=0: rsp_valid=10, data=FFFF, NF=1, CF=0, ZF=0; ccr unchanged at 101.
- Both ports valid continuously (INC a=0001): grants alternate 0,1,0,1; each response arrives 2 cycles after its grant. With ALU_SHARE_FIXED_PRIO_EN, port 0 is granted every time.
- r0 op=7'b000_0011 (not one-hot), setf=1: alu_en stays 0; rsp_err=1, data=0; ccr unchanged.
- Hold rsp_ready[0]=0 for 5 cycles while r1 is valid: rsp_data stays stable and r1_ready=0. Raise rsp_ready[0]: r1 is accepted in that same cycle and reaches EXEC next cycle.
- Drive rst_n=0 during EXEC of a setf op: the next cycle shows IDLE, rsp_valid=00, ccr=000, and no response for the dropped op.
